mig_app_arbiter: RTL and testbench

MIG_APP_ARBITER -- requirements
Module: mig_app_arbiter

---
 rtl/mig_app_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mig_app_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_app_arbiter.sv
// mig_app_arbiter: two-requester front end for a MIG user (app_*) interface.
// Issues one command at a time, drives the command and write-data channels
// independently, and routes read returns back to the issuing requester via an
// in-order tag FIFO.
// Build option: define MIG_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module mig_app_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 256,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  ui_clk,
  input  logic                  ui_clk_sync_rst,
  input  logic                  calib_done,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [2:0]            r0_cmd,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rd_valid,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [2:0]            r1_cmd,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  tag_err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state_q, state_d;
  logic                    app_en_q, app_en_d;
  logic                    wren_q, wren_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    own_q, own_d;     // requester that owns the command in ISSUE

  logic [TAG_DEPTH-1:0]    tag_mem_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PW:0]             cnt_q;
  logic                    tag_full, tag_empty, tag_push, tag_pop, tag_head;
  logic                    tag_err_q;

  logic                    elig0, elig1, g_sel1, grant;
  logic [2:0]              g_cmd;

  assign tag_full  = (cnt_q == (PW+1)'(TAG_DEPTH));
  assign tag_empty = (cnt_q == '0);
  assign tag_head  = tag_mem_q[rd_ptr_q];
  assign tag_push  = app_en_q & app_rdy & (cmd_q == CMD_RD);
  assign tag_pop   = app_rd_data_valid & ~tag_empty;

  // A read is only eligible while a tag slot is free; writes/illegal always are.
  assign elig0 = r0_valid & ((r0_cmd != CMD_RD) | ~tag_full);
  assign elig1 = r1_valid & ((r1_cmd != CMD_RD) | ~tag_full);

`ifdef MIG_ARB_ROUND_ROBIN_EN
  logic prio_q;   // 1: requester 1 wins a tie
  assign g_sel1 = elig1 & (~elig0 | prio_q);

  // Round-robin pointer: the requester not just granted wins the next tie.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) prio_q <= 1'b0;
    else if (grant)      prio_q <= ~g_sel1;
  end
`else
  assign g_sel1 = elig1 & ~elig0;
`endif

  assign grant = ~ui_clk_sync_rst & (state_q == IDLE) & calib_done & (elig0 | elig1);
  assign g_cmd = g_sel1 ? r1_cmd : r0_cmd;

  // Next-state and handshake logic; each channel clears on its own accept.
  always_comb begin
    state_d  = state_q;
    app_en_d = app_en_q;
    wren_d   = wren_q;
    addr_d   = addr_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    own_d    = own_q;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          r0_ready = ~g_sel1;
          r1_ready = g_sel1;
          // Illegal opcodes are acknowledged but never reach the MIG.
          if (g_cmd == CMD_WR || g_cmd == CMD_RD) begin
            addr_d   = g_sel1 ? r1_addr  : r0_addr;
            wdata_d  = g_sel1 ? r1_wdata : r0_wdata;
            cmd_d    = g_cmd;
            own_d    = g_sel1;
            app_en_d = 1'b1;
            wren_d   = (g_cmd == CMD_WR);
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (app_en_q && app_rdy)   app_en_d = 1'b0;
        if (wren_q && app_wdf_rdy) wren_d   = 1'b0;
        if (!app_en_d && !wren_d)  state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and MIG-facing command registers.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q  <= IDLE;
      app_en_q <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      cmd_q    <= '0;
      wdata_q  <= '0;
      own_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      app_en_q <= app_en_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      own_q    <= own_d;
    end
  end

  // Tag FIFO: requester IDs of accepted reads, popped in return order.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      tag_mem_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      if (tag_push) begin
        tag_mem_q[wr_ptr_q] <= own_q;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (tag_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (tag_push && !tag_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!tag_push && tag_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Sticky error: read data with no outstanding tag to route it.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst)                      tag_err_q <= 1'b0;
    else if (app_rd_data_valid && tag_empty) tag_err_q <= 1'b1;
  end

  assign rd_data      = app_rd_data;
  assign r0_rd_valid  = tag_pop & ~tag_head & ~ui_clk_sync_rst;
  assign r1_rd_valid  = tag_pop &  tag_head & ~ui_clk_sync_rst;
  assign app_addr     = addr_q;
  assign app_cmd      = cmd_q;
  assign app_en       = app_en_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wren_q;
  assign tag_err      = tag_err_q;

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Bench for mig_app_arbiter: directed scenarios plus a transaction-level
// model (command/write-data/tag queues) checked on every falling edge.
module tb_mig_app_arbiter;
  localparam int AW = 28;
  localparam int DW = 256;
  localparam int TD = 4;
  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;
  localparam logic [DW-1:0] D_CAFE = {8{32'hcafebabe}};
  localparam logic [DW-1:0] D_AA55 = {8{32'hAA55AA55}};
  localparam logic [DW-1:0] D_55AA = {8{32'h55AA55AA}};

  logic ui_clk, ui_clk_sync_rst, calib_done;
  logic r0_valid, r0_ready, r0_rd_valid, r1_valid, r1_ready, r1_rd_valid;
  logic [2:0] r0_cmd, r1_cmd, app_cmd;
  logic [AW-1:0] r0_addr, r1_addr, app_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, rd_data, app_wdf_data, app_rd_data;
  logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid, tag_err;

  mig_app_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst), .calib_done(calib_done),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_cmd(r0_cmd), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rd_valid(r0_rd_valid),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_cmd(r1_cmd), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rd_valid(r1_rd_valid), .rd_data(rd_data),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .tag_err(tag_err));

  initial begin
    ui_clk = 1'b0;
    forever #5 ui_clk = ~ui_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct { logic [2:0] cmd; logic [AW-1:0] addr; } cmd_t;
  cmd_t          cmd_q[$];
  logic [DW-1:0] wdf_q[$];
  bit            tag_q[$];
  int            grants[$];
  bit            m_tag_err;
  int            last_g;
  int            cyc, en_cnt, wren_cnt, wdf_acc_cnt, wdf_acc_cyc;
  int            rdy0_cnt, rdy1_cnt, rdy1_cyc, rdv0_cnt, rdv1_cnt;
  logic [AW-1:0] last_addr;
  logic [2:0]    last_cmd;
  logic [DW-1:0] last_wdata, last_rd0, last_rd1;
  int            occ, g;
  bit            exp_rv, head, e0, e1;
  logic [2:0]    gc;
  cmd_t          ce;

  initial begin : compare
    cyc = 0; en_cnt = 0; wren_cnt = 0; wdf_acc_cnt = 0; wdf_acc_cyc = 0;
    rdy0_cnt = 0; rdy1_cnt = 0; rdy1_cyc = 0; rdv0_cnt = 0; rdv1_cnt = 0;
    m_tag_err = 0; last_g = 1;
    forever begin
      @(negedge ui_clk);
      cyc++;
      if (ui_clk_sync_rst) begin
        chk("rst_ready", 256'({r0_ready, r1_ready}), 256'(0));
        chk("rst_rd_valid", 256'({r0_rd_valid, r1_rd_valid}), 256'(0));
        cmd_q.delete(); wdf_q.delete(); tag_q.delete();
        m_tag_err = 0; last_g = 1;
      end else begin
        occ = tag_q.size();
        chk("wdf_end", 256'(app_wdf_end), 256'(app_wdf_wren));
        chk("tag_err", 256'(tag_err), 256'(m_tag_err));
        // command channel must carry the oldest granted legal command
        if (app_en) begin
          en_cnt++;
          if (cmd_q.size() == 0) chk("app_en_without_cmd", 256'(1), 256'(0));
          else begin
            chk("app_addr", 256'(app_addr), 256'(cmd_q[0].addr));
            chk("app_cmd", 256'(app_cmd), 256'(cmd_q[0].cmd));
            if (app_rdy) begin
              last_addr = app_addr; last_cmd = app_cmd;
              void'(cmd_q.pop_front());
            end
          end
        end
        if (app_wdf_wren) begin
          wren_cnt++;
          if (wdf_q.size() == 0) chk("wren_without_write", 256'(1), 256'(0));
          else begin
            chk("app_wdf_data", 256'(app_wdf_data), 256'(wdf_q[0]));
            if (app_wdf_rdy) begin
              last_wdata = app_wdf_data; wdf_acc_cnt++; wdf_acc_cyc = cyc;
              void'(wdf_q.pop_front());
            end
          end
        end
        // read return routing
        exp_rv = app_rd_data_valid && (occ > 0);
        head   = (occ > 0) ? tag_q[0] : 1'b0;
        chk("r0_rd_valid", 256'(r0_rd_valid), 256'(exp_rv && !head));
        chk("r1_rd_valid", 256'(r1_rd_valid), 256'(exp_rv && head));
        if (exp_rv) begin
          chk("rd_data", 256'(rd_data), 256'(app_rd_data));
          if (head) begin rdv1_cnt++; last_rd1 = app_rd_data; end
          else      begin rdv0_cnt++; last_rd0 = app_rd_data; end
          void'(tag_q.pop_front());
        end else if (app_rd_data_valid) m_tag_err = 1;
        // grants
        if (r0_ready || r1_ready) begin
          chk("single_ready", 256'(r0_ready && r1_ready), 256'(0));
          g  = r1_ready ? 1 : 0;
          e0 = r0_valid && (r0_cmd != RD || occ < TD);
          e1 = r1_valid && (r1_cmd != RD || occ < TD);
          chk("ready_eligible", 256'(g ? e1 : e0), 256'(1));
          chk("ready_calib", 256'(calib_done), 256'(1));
`ifdef MIG_ARB_ROUND_ROBIN_EN
          if (e0 && e1) chk("priority", 256'(g), 256'(1 - last_g));
`else
          if (e0 && e1) chk("priority", 256'(g), 256'(0));
`endif
          grants.push_back(g);
          last_g = g;
          if (g == 1) begin rdy1_cnt++; rdy1_cyc = cyc; end
          else rdy0_cnt++;
          gc = g ? r1_cmd : r0_cmd;
          if (gc == WR || gc == RD) begin
            ce.cmd = gc; ce.addr = g ? r1_addr : r0_addr;
            cmd_q.push_back(ce);
          end
          if (gc == WR) wdf_q.push_back(g ? r1_wdata : r0_wdata);
          if (gc == RD) tag_q.push_back(g[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge ui_clk); #1;
  endtask

  task automatic drive(input int n, input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin r0_valid = 1'b1; r0_cmd = c; r0_addr = a; r0_wdata = d; end
    else        begin r1_valid = 1'b1; r1_cmd = c; r1_addr = a; r1_wdata = d; end
  endtask

  task automatic wait_rdy(input int n);
    bit got;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge ui_clk);
      got = (n == 1) ? r1_ready : r0_ready;
    end
    if (!got) chk("ready_timeout", 256'(0), 256'(1));
    @(posedge ui_clk); #1;
    if (n == 1) r1_valid = 1'b0; else r0_valid = 1'b0;
  endtask

  task automatic req(input int n, input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(n, c, a, d);
    wait_rdy(n);
  endtask

  task automatic ret(input logic [DW-1:0] d);
    app_rd_data = d; app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
  endtask

  int s_en, s_wren, s_rdy0, s_rdy1, s_rdv0, s_rdv1, s_acc, base, k;

  initial begin : stim
    ui_clk_sync_rst = 1'b1; calib_done = 1'b0;
    r0_valid = 0; r0_cmd = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_cmd = 0; r1_addr = 0; r1_wdata = 0;
    app_rdy = 0; app_wdf_rdy = 0; app_rd_data = 0; app_rd_data_valid = 0;
    repeat (3) tick();
    chk("reset_app_en", 256'(app_en), 256'(0));
    chk("reset_wren", 256'(app_wdf_wren), 256'(0));
    chk("reset_tag_err", 256'(tag_err), 256'(0));
    chk("reset_app_addr", 256'(app_addr), 256'(0));
    chk("reset_app_cmd", 256'(app_cmd), 256'(0));
    chk("reset_wdf_data", 256'(app_wdf_data), 256'(0));
    ui_clk_sync_rst = 1'b0; calib_done = 1'b1; app_rdy = 1; app_wdf_rdy = 1;
    tick();

    // single write
    s_en = en_cnt; s_wren = wren_cnt; s_rdy0 = rdy0_cnt;
    req(0, WR, 28'h0000100, D_CAFE);
    tick(); tick();
    chk("wr_en_cycles", 256'(en_cnt - s_en), 256'(1));
    chk("wr_wren_cycles", 256'(wren_cnt - s_wren), 256'(1));
    chk("wr_ready_pulses", 256'(rdy0_cnt - s_rdy0), 256'(1));
    chk("wr_addr", 256'(last_addr), 256'(28'h0000100));
    chk("wr_cmd", 256'(last_cmd), 256'(WR));
    chk("wr_data", 256'(last_wdata), 256'(D_CAFE));

    // channel skew: wdf accepted five cycles after the command
    s_en = en_cnt; s_wren = wren_cnt;
    app_wdf_rdy = 0;
    req(0, WR, 28'h0000140, D_55AA);
    drive(1, WR, 28'h0000180, D_AA55);
    repeat (5) tick();
    app_wdf_rdy = 1;
    wait_rdy(1);
    chk("skew_en_cycles", 256'(en_cnt - s_en), 256'(1));
    chk("skew_wren_cycles", 256'(wren_cnt - s_wren), 256'(6));
    chk("skew_idle_gap", 256'(rdy1_cyc - wdf_acc_cyc), 256'(1));
    tick(); tick();

    // contention
    base = grants.size();
    drive(0, WR, 28'h0000200, D_CAFE);
    drive(1, WR, 28'h0000300, D_AA55);
    for (k = 0; k < 40 && grants.size() < base + 4; k++) tick();
    r0_valid = 0; r1_valid = 0;
    if (grants.size() < base + 4) chk("contention_timeout", 256'(grants.size() - base), 256'(4));
    else begin
      for (int i = 0; i < 4; i++)
`ifdef MIG_ARB_ROUND_ROBIN_EN
        chk("contention_order", 256'(grants[base + i]), 256'(i % 2));
`else
        chk("contention_order", 256'(grants[base + i]), 256'(0));
`endif
    end
    tick(); tick();

    // tag FIFO full blocks reads, not the other requester's write
    s_rdv0 = rdv0_cnt; s_rdv1 = rdv1_cnt;
    for (int i = 0; i < 4; i++) req(1, RD, 28'h0000400 + 28'(i), '0);
    drive(1, RD, 28'h0000404, '0);
    drive(0, WR, 28'h0000480, D_CAFE);
    wait_rdy(0);
    s_rdy1 = rdy1_cnt;
    repeat (6) tick();
    chk("full_read_blocked", 256'(rdy1_cnt - s_rdy1), 256'(0));
    ret({8{32'h11110000}});
    wait_rdy(1);
    tick();
    for (int i = 1; i < 5; i++) ret({8{32'h11110000 + 32'(i)}});
    chk("full_r1_returns", 256'(rdv1_cnt - s_rdv1), 256'(5));
    chk("full_r0_returns", 256'(rdv0_cnt - s_rdv0), 256'(0));
    chk("full_last_data", 256'(last_rd1), 256'({8{32'h11110004}}));

    // interleaved reads
    s_rdv0 = rdv0_cnt; s_rdv1 = rdv1_cnt;
    req(0, RD, 28'h0000500, '0);
    req(1, RD, 28'h0000600, '0);
    tick();
    ret(D_AA55);
    ret(D_55AA);
    chk("ilv_r0_count", 256'(rdv0_cnt - s_rdv0), 256'(1));
    chk("ilv_r1_count", 256'(rdv1_cnt - s_rdv1), 256'(1));
    chk("ilv_r0_data", 256'(last_rd0), 256'(D_AA55));
    chk("ilv_r1_data", 256'(last_rd1), 256'(D_55AA));

    // illegal opcode: acknowledged, no MIG traffic
    s_en = en_cnt; s_rdy0 = rdy0_cnt;
    req(0, 3'b111, 28'h0000700, D_CAFE);
    repeat (3) tick();
    chk("illegal_ready", 256'(rdy0_cnt - s_rdy0), 256'(1));
    chk("illegal_no_en", 256'(en_cnt - s_en), 256'(0));

    // calibration gating
    calib_done = 0;
    s_rdy0 = rdy0_cnt;
    drive(0, WR, 28'h0000710, D_55AA);
    repeat (5) tick();
    chk("calib_no_grant", 256'(rdy0_cnt - s_rdy0), 256'(0));
    calib_done = 1;
    wait_rdy(0);
    tick(); tick();
    // calib drop during ISSUE still completes the command
    app_wdf_rdy = 0;
    s_acc = wdf_acc_cnt;
    req(0, WR, 28'h0000720, D_AA55);
    calib_done = 0;
    repeat (3) tick();
    app_wdf_rdy = 1;
    tick(); tick();
    chk("calib_issue_completes", 256'(wdf_acc_cnt - s_acc), 256'(1));
    calib_done = 1;

    // spurious return
    ret(D_CAFE);
    chk("spurious_tag_err", 256'(tag_err), 256'(1));
    repeat (3) tick();
    chk("tag_err_sticky", 256'(tag_err), 256'(1));
    ui_clk_sync_rst = 1; tick(); ui_clk_sync_rst = 0; tick();
    chk("tag_err_cleared", 256'(tag_err), 256'(0));

    // reset mid-ISSUE aborts; the late read return is an error
    app_rdy = 0;
    req(0, RD, 28'h0000800, '0);
    chk("abort_en_before", 256'(app_en), 256'(1));
    tick();
    ui_clk_sync_rst = 1; tick();
    chk("abort_en_reset", 256'(app_en), 256'(0));
    chk("abort_cmd_reset", 256'(app_cmd), 256'(0));
    ui_clk_sync_rst = 0; app_rdy = 1;
    repeat (3) tick();
    chk("abort_no_retry", 256'(app_en), 256'(0));
    ret(D_55AA);
    chk("abort_late_return_err", 256'(tag_err), 256'(1));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
